// File: rtl/rv32i_regalu_datapath_pkg.sv
// Shared types for the RV32I multicycle datapath and its control unit.
//   alu_control_t : 4-bit ALU operation select driven by the control FSM.
//   alu_name()    : operation name string for debug printing.
//   OP_* / FUNCT3_* / FUNCT7_* : instruction decode constants for the control unit.
package rv32i_regalu_datapath_pkg;

  typedef enum logic [3:0] {
    ALU_INVALID = 4'b0000,
    ALU_AND     = 4'b0001,
    ALU_OR      = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SLL     = 4'b0101,
    ALU_SRL     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_ADD     = 4'b1000,
    ALU_SUB     = 4'b1100,
    ALU_SLT     = 4'b1101,
    ALU_SLTU    = 4'b1111
  } alu_control_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LTYPE = 7'b0000011;
  localparam logic [6:0] OP_STYPE = 7'b0100011;
  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SHR  = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  function automatic string alu_name(alu_control_t op);
    case (op)
      ALU_AND:  return "AND";
      ALU_OR:   return "OR";
      ALU_XOR:  return "XOR";
      ALU_SLL:  return "SLL";
      ALU_SRL:  return "SRL";
      ALU_SRA:  return "SRA";
      ALU_ADD:  return "ADD";
      ALU_SUB:  return "SUB";
      ALU_SLT:  return "SLT";
      ALU_SLTU: return "SLTU";
      default:  return "INVALID";
    endcase
  endfunction

endpackage

// File: rtl/rv32i_regalu_datapath_register.sv
// Generic N-bit state flop with synchronous active-high reset and load enable.
//   clk, rst : clock, synchronous reset to RESET
//   ena      : load d into q on the rising edge
//   d / q    : next / current value
module rv32i_regalu_datapath_register #(
  parameter int unsigned   N     = 32,
  parameter logic [N-1:0]  RESET = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rv32i_regalu_datapath.sv
// Datapath core of the RV32I multicycle CPU: 32x32 register file, combinational
// ALU, and the PC / PC_old / ALU-out registers. All sequencing comes from the
// control unit; this block only holds architectural state and computes results.
//   clk, rst          : clock, synchronous active-high reset (beats ena and writes)
//   ena               : global enable, 0 freezes every piece of state
//   pc_ena, pc_d      : load pc_q <= pc_d and pc_old_q <= pc_q together
//   pc_q, pc_old_q    : current PC and PC of the executing instruction
//   rf_wr_*           : register-file write port (x0 is hardwired to zero)
//   rf_rd_addr0/1     : asynchronous read ports, no write bypass
//   alu_a/b/control   : ALU operands and operation select
//   alu_result        : combinational ALU result, alu_out_q its registered copy
//   overflow/zero/equal : ALU status flags
module rv32i_regalu_datapath
  import rv32i_regalu_datapath_pkg::*;
#(
  parameter logic [31:0] PC_START_ADDRESS = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        pc_ena,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q,
  output logic [31:0] pc_old_q,
  input  logic        rf_wr_ena,
  input  logic [4:0]  rf_wr_addr,
  input  logic [31:0] rf_wr_data,
  input  logic [4:0]  rf_rd_addr0,
  input  logic [4:0]  rf_rd_addr1,
  output logic [31:0] rf_rd_data0,
  output logic [31:0] rf_rd_data1,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [3:0]  alu_control,
  output logic [31:0] alu_result,
  output logic [31:0] alu_out_q,
  output logic        overflow,
  output logic        zero,
  output logic        equal
);

  // ---------------- PC pair and ALU-out registers ----------------
  logic pc_load;
  assign pc_load = ena & pc_ena;

  rv32i_regalu_datapath_register #(.N(32), .RESET(PC_START_ADDRESS)) u_pc (
    .clk(clk), .rst(rst), .ena(pc_load), .d(pc_d), .q(pc_q)
  );

  // Captures the pre-update PC on the same edge the PC advances.
  rv32i_regalu_datapath_register #(.N(32), .RESET(32'h0)) u_pc_old (
    .clk(clk), .rst(rst), .ena(pc_load), .d(pc_q), .q(pc_old_q)
  );

  rv32i_regalu_datapath_register #(.N(32), .RESET(32'h0)) u_alu_out (
    .clk(clk), .rst(rst), .ena(ena), .d(alu_result), .q(alu_out_q)
  );

  // ---------------- Register file ----------------
  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (ena && rf_wr_ena && (rf_wr_addr != 5'd0)) begin
      regs_q[rf_wr_addr] <= rf_wr_data;
    end
  end

  // x0 is forced to zero on the read side; no bypass of the in-flight write.
  assign rf_rd_data0 = (rf_rd_addr0 == 5'd0) ? 32'h0 : regs_q[rf_rd_addr0];
  assign rf_rd_data1 = (rf_rd_addr1 == 5'd0) ? 32'h0 : regs_q[rf_rd_addr1];

  // ---------------- ALU ----------------
  alu_control_t alu_op;
  logic [4:0]   shamt;

  assign alu_op = alu_control_t'(alu_control);
  assign shamt  = alu_b[4:0];

  always_comb begin
    alu_result = 32'h0;
    overflow   = 1'b0;
    case (alu_op)
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> shamt);
      ALU_ADD: begin
        alu_result = alu_a + alu_b;
        // Same-sign operands producing a differently signed sum.
        overflow   = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      ALU_SUB: begin
        alu_result = alu_a - alu_b;
        // a + ~b view: operands of opposite sign and result sign flipped from a.
        overflow   = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      ALU_SLT:  alu_result = {31'h0, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: alu_result = {31'h0, (alu_a < alu_b)};
      default: begin
        alu_result = 32'h0;
        overflow   = 1'b0;
      end
    endcase
  end

  assign zero  = (alu_result == 32'h0);
  assign equal = (alu_a == alu_b);

endmodule

// File: tb/tb_rv32i_regalu_datapath.sv
module tb_rv32i_regalu_datapath;

  localparam logic [31:0] PC_START = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        pc_ena;
  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic [31:0] pc_old_q;
  logic        rf_wr_ena;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [4:0]  rf_rd_addr0;
  logic [4:0]  rf_rd_addr1;
  logic [31:0] rf_rd_data0;
  logic [31:0] rf_rd_data1;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic [31:0] alu_out_q;
  logic        overflow;
  logic        zero;
  logic        equal;

  int checks;
  int failures;

  // Reference state
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  logic [31:0] m_pc_old;
  logic [31:0] m_alu_out;

  rv32i_regalu_datapath #(.PC_START_ADDRESS(PC_START)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pc_ena(pc_ena), .pc_d(pc_d),
    .pc_q(pc_q), .pc_old_q(pc_old_q),
    .rf_wr_ena(rf_wr_ena), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
    .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_out_q(alu_out_q),
    .overflow(overflow), .zero(zero), .equal(equal)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd1:  return a & b;
      4'd2:  return a | b;
      4'd3:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $signed(a) >>> sh;
      4'd8:  return a + b;
      4'd12: return a - b;
      4'd13: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd15: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Overflow judged by whether the exact signed result fits in 32 bits.
  function automatic logic ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    if (op == 4'd8)       s = sa + sb;
    else if (op == 4'd12) s = sa - sb;
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] addr);
    return (addr == 5'd0) ? 32'd0 : m_rf[addr];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rst = 1'b0; ena = 1'b1; pc_ena = 1'b0; pc_d = 32'h0;
    rf_wr_ena = 1'b0; rf_wr_addr = 5'd0; rf_wr_data = 32'h0;
    rf_rd_addr0 = 5'd0; rf_rd_addr1 = 5'd0;
    alu_a = 32'h0; alu_b = 32'h0; alu_control = 4'd0;
  endtask

  // Checks combinational outputs against current model state (inputs already driven).
  task automatic check_comb();
    logic [31:0] r;
    #1;
    r = ref_result(alu_control, alu_a, alu_b);
    check_val("rd0", rf_rd_data0, ref_read(rf_rd_addr0));
    check_val("rd1", rf_rd_data1, ref_read(rf_rd_addr1));
    check_val("alu_result", alu_result, r);
    check_val("overflow", {31'd0, overflow}, {31'd0, ref_ovf(alu_control, alu_a, alu_b)});
    check_val("zero", {31'd0, zero}, {31'd0, (r == 32'd0)});
    check_val("equal", {31'd0, equal}, {31'd0, (alu_a == alu_b)});
  endtask

  // One clock edge; model updated from the inputs present at the edge, then state checked.
  task automatic clock_step();
    logic [31:0] r;
    r = ref_result(alu_control, alu_a, alu_b);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_pc = PC_START; m_pc_old = 32'd0; m_alu_out = 32'd0;
    end else if (ena) begin
      if (rf_wr_ena && rf_wr_addr != 5'd0) m_rf[rf_wr_addr] = rf_wr_data;
      if (pc_ena) begin
        m_pc_old = m_pc;
        m_pc     = pc_d;
      end
      m_alu_out = r;
    end
    #2;
    check_val("pc_q", pc_q, m_pc);
    check_val("pc_old_q", pc_old_q, m_pc_old);
    check_val("alu_out_q", alu_out_q, m_alu_out);
  endtask

  task automatic step();
    check_comb();
    clock_step();
  endtask

  task automatic alu_dir(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic exp_ovf);
    drive_idle();
    alu_control = op; alu_a = a; alu_b = b;
    check_comb();
    check_val(tag, alu_result, exp);
    check_val({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    clock_step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] ops [11];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd13, 4'd15};
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'hX;
    m_pc = 32'hX; m_pc_old = 32'hX; m_alu_out = 32'hX;

    // Reset, with ena and writes asserted to confirm reset dominates.
    drive_idle();
    rst = 1'b1; pc_ena = 1'b1; pc_d = 32'h55; rf_wr_ena = 1'b1; rf_wr_addr = 5'd3; rf_wr_data = 32'hFFFF;
    @(negedge clk);
    clock_step();
    clock_step();
    check_val("reset_pc", pc_q, PC_START);
    check_val("reset_pc_old", pc_old_q, 32'd0);

    // All registers read zero after reset.
    for (int i = 0; i < 32; i += 2) begin
      drive_idle();
      ena = 1'b0;
      rf_rd_addr0 = 5'(i); rf_rd_addr1 = 5'(i + 1);
      check_comb();
      check_val("reset_rf0", rf_rd_data0, 32'd0);
      check_val("reset_rf1", rf_rd_data1, 32'd0);
      clock_step();
    end

    // x5 write: same-cycle read shows old value, next cycle shows new.
    drive_idle();
    rf_wr_ena = 1'b1; rf_wr_addr = 5'd5; rf_wr_data = 32'hDEADBEEF;
    rf_rd_addr0 = 5'd5; rf_rd_addr1 = 5'd5;
    check_comb();
    check_val("x5_same_cycle", rf_rd_data0, 32'd0);
    clock_step();
    drive_idle();
    rf_wr_ena = 1'b1; rf_wr_addr = 5'd0; rf_wr_data = 32'h1234;
    rf_rd_addr0 = 5'd5; rf_rd_addr1 = 5'd5;
    check_comb();
    check_val("x5_new", rf_rd_data0, 32'hDEADBEEF);
    check_val("x5_port1", rf_rd_data1, 32'hDEADBEEF);
    clock_step();
    drive_idle();
    rf_rd_addr0 = 5'd0;
    check_comb();
    check_val("x0_zero", rf_rd_data0, 32'd0);
    clock_step();

    // Directed ALU cases.
    alu_dir("add_ovf", 4'd8, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1);
    alu_dir("sub_zero", 4'd12, 32'd5, 32'd5, 32'd0, 1'b0);
    check_val("alu_out_lat", alu_out_q, 32'd0);
    alu_dir("sra", 4'd7, 32'h80000000, 32'h24, 32'hF8000000, 1'b0);
    alu_dir("srl", 4'd6, 32'h80000000, 32'h24, 32'h08000000, 1'b0);
    alu_dir("sll", 4'd5, 32'd1, 32'd31, 32'h80000000, 1'b0);
    alu_dir("slt", 4'd13, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    alu_dir("sltu", 4'd15, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    alu_dir("invalid", 4'd0, 32'h1234, 32'h5678, 32'd0, 1'b0);
    alu_dir("sub_ovf", 4'd12, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1);
    alu_dir("unlisted", 4'd4, 32'hFFFF, 32'hFF, 32'd0, 1'b0);

    // PC pair.
    drive_idle(); pc_ena = 1'b1; pc_d = 32'd4;
    step();
    check_val("pc_4", pc_q, 32'd4);
    check_val("pc_old_start", pc_old_q, PC_START);
    drive_idle(); pc_ena = 1'b1; pc_d = 32'd8;
    step();
    check_val("pc_8", pc_q, 32'd8);
    check_val("pc_old_4", pc_old_q, 32'd4);

    // ena=0 freezes everything.
    drive_idle(); ena = 1'b0; pc_ena = 1'b1; pc_d = 32'h40;
    rf_wr_ena = 1'b1; rf_wr_addr = 5'd5; rf_wr_data = 32'h0BAD0BAD;
    alu_control = 4'd8; alu_a = 32'd7; alu_b = 32'd9;
    step();
    drive_idle(); ena = 1'b0; rf_rd_addr0 = 5'd5;
    check_comb();
    check_val("ena0_rf_hold", rf_rd_data0, 32'hDEADBEEF);
    check_val("ena0_pc_hold", pc_q, 32'd8);
    clock_step();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      drive_idle();
      rst         = ($urandom_range(0, 99) == 0);
      ena         = ($urandom_range(0, 9) != 0);
      pc_ena      = $urandom_range(0, 1);
      pc_d        = $urandom;
      rf_wr_ena   = ($urandom_range(0, 3) != 0);
      rf_wr_addr  = 5'($urandom_range(0, 31));
      rf_wr_data  = $urandom;
      rf_rd_addr0 = 5'($urandom_range(0, 31));
      rf_rd_addr1 = ($urandom_range(0, 3) == 0) ? rf_rd_addr0 : 5'($urandom_range(0, 31));
      alu_a       = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      alu_b       = ($urandom_range(0, 7) == 0) ? alu_a : $urandom;
      alu_control = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                : ops[$urandom_range(0, 10)];
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
